// File: rtl/delay_trainer_if.sv
// Delay control bus between the trainer (master) and the delay control
// block (slave): tap stepping/load strobes out, current tap value back.
interface delay_trainer_if;
  logic       faster;
  logic       slower;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] delay_cur;

  modport master (output faster, output slower, output write, output writedata,
                  input delay_cur);
  modport slave  (input faster, input slower, input write, input writedata,
                  output delay_cur);
endinterface

// File: rtl/delay_trainer.sv
// delay_trainer: sweeps the delay tap DELAY_MIN..DELAY_MAX, counts receiver
// errors over WINDOW_LEN valid samples per tap, tracks the longest error-free
// run and writes back its centre (or the original tap if nothing passed).
// Optional macro DELAY_TRAINER_THRESH_EN adds err_thresh: a tap passes when
// its error count is <= the threshold sampled at start.
module delay_trainer #(
  parameter int DELAY_MIN     = 8,
  parameter int DELAY_MAX     = 15,
  parameter int WINDOW_LEN    = 256,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  localparam int NTAPS        = DELAY_MAX - DELAY_MIN + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                sample_valid,
  input  logic                sample_error,
`ifdef DELAY_TRAINER_THRESH_EN
  input  logic [CNT_W-1:0]    err_thresh,
`endif
  delay_trainer_if.master     dc,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [7:0]          best_delay,
  output logic [NTAPS-1:0]    pass_mask
);
  localparam int IDX_W = $clog2(NTAPS);
  localparam int SMP_W = $clog2(WINDOW_LEN + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, MEASURE, STEP, APPLY} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [SET_W-1:0]   settle_cnt;
  logic [SMP_W-1:0]   smp_cnt;
  logic [CNT_W-1:0]   err_cnt, err_nxt;
  logic [7:0]         orig;
  logic [7:0]         cur_start, cur_len, best_start, best_len;
  logic [7:0]         run_start_nxt, run_len_nxt, apply_data;
  logic               win_end, settle_end, tap_pass;
`ifdef DELAY_TRAINER_THRESH_EN
  logic [CNT_W-1:0]   thresh_q;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != '1)) return v + 1'b1;
    else                  return v;
  endfunction

  function automatic logic [7:0] run_centre(input logic [7:0] s,
                                            input logic [7:0] l);
    return 8'(DELAY_MIN) + s + ((l - 8'd1) >> 1);
  endfunction

  assign err_nxt       = sat_inc(err_cnt, sample_valid & sample_error);
  assign win_end       = (state == MEASURE) && sample_valid &&
                         (smp_cnt == SMP_W'(WINDOW_LEN - 1));
  assign settle_end    = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
`ifdef DELAY_TRAINER_THRESH_EN
  assign tap_pass      = (err_nxt <= thresh_q);
`else
  assign tap_pass      = (err_nxt == '0);
`endif
  assign run_len_nxt   = cur_len + 8'd1;
  assign run_start_nxt = (cur_len == 8'd0) ? 8'(idx) : cur_start;
  assign apply_data    = (best_len != 8'd0) ? run_centre(best_start, best_len) : orig;
  assign busy          = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = SETTLE;
      SETTLE:  if (settle_end) state_nxt = MEASURE;
      MEASURE: if (win_end) state_nxt = (idx == IDX_W'(NTAPS - 1)) ? APPLY : STEP;
      STEP:    state_nxt = SETTLE;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Delay control strobes, decoded from the state only so write/slower never overlap
  always_comb begin
    dc.faster    = 1'b0;
    dc.slower    = 1'b0;
    dc.write     = 1'b0;
    dc.writedata = 8'd0;
    case (state)
      LOAD:  begin dc.write = 1'b1; dc.writedata = 8'(DELAY_MIN); end
      STEP:  dc.slower = 1'b1;
      APPLY: begin dc.write = 1'b1; dc.writedata = apply_data; end
      default: ;
    endcase
  end

  // Control counters and sticky result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      settle_cnt <= '0;
      pass_mask  <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
      best_delay <= 8'd0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
      case (state)
        IDLE: if (start) begin
          pass_mask <= '0;
          done      <= 1'b0;
          fail      <= 1'b0;
        end
        LOAD:    idx <= '0;
        STEP:    idx <= idx + 1'b1;
        MEASURE: if (win_end) pass_mask[idx] <= tap_pass;
        APPLY: begin
          best_delay <= apply_data;
          if (best_len != 8'd0) done <= 1'b1;
          else                  fail <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-tap sample/error counters and incremental best-run tracking
  always_ff @(posedge clk) begin
    if (state == MEASURE) begin
      if (sample_valid) smp_cnt <= smp_cnt + 1'b1;
      err_cnt <= err_nxt;
    end else begin
      smp_cnt <= '0;
      err_cnt <= '0;
    end
    if ((state == IDLE) && start) begin
      orig       <= dc.delay_cur;
      cur_start  <= 8'd0;
      cur_len    <= 8'd0;
      best_start <= 8'd0;
      best_len   <= 8'd0;
`ifdef DELAY_TRAINER_THRESH_EN
      thresh_q   <= err_thresh;
`endif
    end else if (win_end) begin
      if (tap_pass) begin
        cur_start <= run_start_nxt;
        cur_len   <= run_len_nxt;
        if (run_len_nxt > best_len) begin
          best_start <= run_start_nxt;
          best_len   <= run_len_nxt;
        end
      end else begin
        cur_len <= 8'd0;
      end
    end
  end
endmodule

// File: doc/delay_trainer.md
Name: delay_trainer

Overview:
Sequencer that owns the faster/slower/write inputs of the delay control block and runs an automatic delay sweep. It steps the delay tap from DELAY_MIN to DELAY_MAX and counts receiver errors over a fixed sample window at each tap. It then selects the centre of the longest error-free run and writes it back. It sits between the receiver's error monitor and the delay control register, and is started by software or top-level logic.

Parameters:
DELAY_MIN, 8, first tap swept; also the value loaded at sweep start.
DELAY_MAX, 15, last tap swept; must be > DELAY_MIN and <= 255.
WINDOW_LEN, 256, valid samples counted per tap.
CNT_W, 16, error counter width; saturates at all-ones.
SETTLE_CYCLES, 4, idle cycles after any tap change before counting starts; must be >= 1.
NTAPS, DELAY_MAX-DELAY_MIN+1, derived; do not override.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a sweep when idle
sample_valid  in  1  one receiver sample this cycle
sample_error  in  1  that sample was wrong; qualified by sample_valid
delay_cur  in  8  current delay value from the delay control block
faster  out  1  to delay control; always 0 (reserved)
slower  out  1  to delay control; one-cycle pulse = +1 tap
write  out  1  to delay control; one-cycle load strobe
writedata  out  8  value loaded when write=1
busy  out  1  sweep in progress
done  out  1  last sweep found a passing tap; sticky until next start
fail  out  1  last sweep found no passing tap; sticky until next start
best_delay  out  8  tap written at the end of the last sweep
pass_mask  out  NTAPS  bit i = tap DELAY_MIN+i passed

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset asserted mid-sweep aborts the sweep immediately. The trainer does not touch the delay control block during reset.
- FSM states: IDLE, LOAD, SETTLE, MEASURE, STEP, APPLY.
- IDLE: start=1 -> capture delay_cur into orig, clear pass_mask/done/fail, go to LOAD. busy rises on the cycle after start.
- start is ignored while busy=1.
- LOAD (1 cycle): write=1, writedata=DELAY_MIN; tap index=0 -> SETTLE.
- SETTLE: count SETTLE_CYCLES cycles. Samples arriving here are ignored. Then go to MEASURE with the error and sample counters cleared.
- MEASURE: each sample_valid increments the sample count. sample_valid&sample_error increments the error count, saturating at 2^CNT_W-1.
- MEASURE ends on the cycle the WINDOW_LEN-th valid sample is counted; that sample is included. On that cycle pass_mask[idx] = (err==0).
- MEASURE exit: idx==NTAPS-1 -> APPLY; else -> STEP.
- STEP (1 cycle): slower=1, idx+1 -> SETTLE.
- Run tracking is incremental during the sweep. Track the current run start and length, and the best run start and length.
- A longer run replaces the best run; an equal-length run does not, so ties go to the lowest start.
- APPLY (1 cycle):
  - If a best run exists: writedata = best_start + (best_len-1)/2 (floor), done=1.
  - Otherwise: writedata = orig, fail=1.
  - In both cases write=1, best_delay=writedata, then go to IDLE with busy=0 on the next cycle.
- write and slower are never asserted in the same cycle. faster is held 0.
- Taps are walked with slower only; delay_cur is not used for sequencing.

Optional Feature:
Macro DELAY_TRAINER_THRESH_EN.
- Defined: adds input err_thresh [CNT_W-1:0]. A tap passes if err <= err_thresh. err_thresh is sampled once at start.
- Undefined: the port is absent and a tap passes only if err==0.

Test Plan:
- All taps error-free, WINDOW_LEN=16 -> pass_mask=8'hFF, best_delay=11, done=1, final write data=11.
- Errors injected on taps 8,9,13,14,15 only -> pass_mask=8'h1C, best_delay=11.
- Taps 8,9 and 12,13 pass, all others error -> tie resolves to run 8..9, best_delay=8.
- Every tap gets one error, delay_cur=10 at start -> fail=1, done=0, final write data=10.
- reset_n low during tap 12 MEASURE -> all outputs 0 asynchronously; after release, no write/slower until the next start.
- start pulsed again while busy=1 -> ignored; exactly one LOAD write, NTAPS-1 slower pulses and one APPLY write per sweep.
